mesi_snoop_controller: RTL and testbench

MESI_SNOOP_CONTROLLER -- requirements
Module: mesi_snoop_controller

---
 rtl/mesi_snoop_controller.sv | 160 ++++++++++++++++
 tb/tb_mesi_snoop_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mesi_snoop_controller.sv
// MESI snoop controller for a two-cache system. Cache 1 issues a read or
// write. The controller decides whether a bus transaction is needed, applies
// the snoop transition to cache 2, and pulses WriteBack when cache 2 flushes
// a modified line.
module mesi_snoop_controller (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Valid,
  input  logic [1:0] WriteRead,
  input  logic [2:0] state1,
  input  logic [2:0] state2,
  output logic       Ready,
  output logic [2:0] Bus,
  output logic [2:0] NewState1,
  output logic [2:0] NewState2,
  output logic       WriteBack,
  output logic       Done,
  output logic       Error,
  output logic [7:0] TxnCount
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_BUS, ST_SNOOP, ST_WB, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    MESI_I = 3'b001, MESI_S = 3'b010, MESI_M = 3'b011, MESI_E = 3'b100
  } mesi_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'b000, BUS_RD = 3'b001, BUS_RDX = 3'b010, BUS_UPGR = 3'b011
  } bus_e;

  state_e     state_q, state_d;
  logic [1:0] wr_q, wr_d;
  logic [2:0] s1_q, s1_d, s2_q, s2_d;
  logic [2:0] ns1_q, ns1_d, ns2_q, ns2_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic       illegal, hit, wb_need, finish;
  logic [2:0] bus_code, n1, n2;

  // Classify the captured request: bus code, resulting states, flush need.
  always_comb begin
    illegal  = wr_q[1]
             || !(s1_q inside {MESI_I, MESI_S, MESI_M, MESI_E})
             || !(s2_q inside {MESI_I, MESI_S, MESI_M, MESI_E});
    bus_code = BUS_NONE;
    n1       = s1_q;
    n2       = s2_q;
    wb_need  = 1'b0;
    if (!illegal) begin
      if (!wr_q[0]) begin
        if (s1_q == MESI_I) begin
          bus_code = BUS_RD;
          n1       = (s2_q == MESI_I) ? MESI_E : MESI_S;
          n2       = (s2_q == MESI_I) ? MESI_I : MESI_S;
          wb_need  = (s2_q == MESI_M);
        end
      end else begin
        case (s1_q)
          MESI_E: n1 = MESI_M;
          MESI_I: begin
            bus_code = BUS_RDX;
            n1       = MESI_M;
            n2       = MESI_I;
            wb_need  = (s2_q == MESI_M);
          end
          MESI_S: begin
            bus_code = BUS_UPGR;
            n1       = MESI_M;
            n2       = MESI_I;
          end
          default: ;
        endcase
      end
    end
    hit = (bus_code == BUS_NONE);
  end

  // Next-state logic; results and count update on the edge entering DONE so
  // they are already valid while Done is high.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    ns1_d   = ns1_q;
    ns2_d   = ns2_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Valid) begin
          wr_d    = WriteRead;
          s1_d    = state1;
          s2_d    = state2;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (hit) finish = 1'b1;
        else     state_d = ST_BUS;
      end
      ST_BUS:   state_d = ST_SNOOP;
      ST_SNOOP: begin
        if (wb_need) state_d = ST_WB;
        else         finish  = 1'b1;
      end
      ST_WB:    finish  = 1'b1;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d = ST_DONE;
      ns1_d   = n1;
      ns2_d   = n2;
      err_d   = illegal;
      cnt_d   = cnt_q + 8'd1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      s1_q    <= MESI_I;
      s2_q    <= MESI_I;
      ns1_q   <= MESI_I;
      ns2_q   <= MESI_I;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      ns1_q   <= ns1_d;
      ns2_q   <= ns2_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are decoded directly from the registered state.
  always_comb begin
    Ready     = (state_q == ST_IDLE);
    Bus       = (state_q == ST_BUS) ? bus_code : BUS_NONE;
    WriteBack = (state_q == ST_WB);
    Done      = (state_q == ST_DONE);
    NewState1 = ns1_q;
    NewState2 = ns2_q;
    Error     = err_q;
    TxnCount  = cnt_q;
  end

endmodule

// File: tb/tb_mesi_snoop_controller.sv
// Directed bench for mesi_snoop_controller with hand-computed expectations.
module tb_mesi_snoop_controller;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Valid;
  logic [1:0] WriteRead;
  logic [2:0] state1, state2;
  logic       Ready;
  logic [2:0] Bus, NewState1, NewState2;
  logic       WriteBack, Done, Error;
  logic [7:0] TxnCount;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_cnt = 8'd0;

  mesi_snoop_controller dut (
    .Clock(Clock), .Reset_n(Reset_n), .Valid(Valid), .WriteRead(WriteRead),
    .state1(state1), .state2(state2), .Ready(Ready), .Bus(Bus),
    .NewState1(NewState1), .NewState2(NewState2), .WriteBack(WriteBack),
    .Done(Done), .Error(Error), .TxnCount(TxnCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge while idle; returns just after a negedge while idle.
  task automatic run_txn(input string name, input logic [1:0] wr, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] ebus, input int ewb,
                         input int elat, input logic [2:0] en1, input logic [2:0] en2,
                         input logic eerr);
    int bus_n = 0;
    int wb_n = 0;
    int done_at = 0;
    logic [2:0] bus_seen = 3'b000;
    check({name, ":ready_pre"}, Ready, 1);
    Valid = 1'b1; WriteRead = wr; state1 = s1; state2 = s2;
    @(posedge Clock); #1;
    Valid = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    for (int k = 1; k <= 8 && done_at == 0; k++) begin
      @(negedge Clock);
      if (Bus != 3'b000) begin bus_n++; bus_seen = Bus; end
      if (WriteBack) wb_n++;
      if (Done) begin
        done_at = k;
        check({name, ":ns1"}, NewState1, en1);
        check({name, ":ns2"}, NewState2, en2);
        check({name, ":err"}, Error, eerr);
        check({name, ":cnt"}, TxnCount, exp_cnt);
      end
    end
    check({name, ":lat"}, done_at, elat);
    check({name, ":bus_cycles"}, bus_n, (ebus != 3'b000) ? 1 : 0);
    check({name, ":bus"}, bus_seen, ebus);
    check({name, ":wb"}, wb_n, ewb);
    @(negedge Clock);
    check({name, ":done_pulse"}, Done, 0);
    check({name, ":ready_post"}, Ready, 1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, ":ready"}, Ready, 1);
    check({name, ":bus"}, Bus, 0);
    check({name, ":done"}, Done, 0);
    check({name, ":wb"}, WriteBack, 0);
    check({name, ":err"}, Error, 0);
    check({name, ":ns1"}, NewState1, 3'b001);
    check({name, ":ns2"}, NewState2, 3'b001);
    check({name, ":cnt"}, TxnCount, 0);
  endtask

  initial begin
    int dones, cyc, last, gap_bad, cnt_bad;
    Reset_n = 1'b0; Valid = 1'b0; WriteRead = 2'b00; state1 = 3'b001; state2 = 3'b001;
    #12;
    check_reset_vals("por");
    @(negedge Clock);
    Reset_n = 1'b1;

    //       name       wr     s1      s2      bus     wb lat ns1     ns2     err
    run_txn("rd_ii",  2'b00, 3'b001, 3'b001, 3'b001, 0, 4, 3'b100, 3'b001, 1'b0);
    run_txn("rd_im",  2'b00, 3'b001, 3'b011, 3'b001, 1, 5, 3'b010, 3'b010, 1'b0);
    run_txn("wr_ss",  2'b01, 3'b010, 3'b010, 3'b011, 0, 4, 3'b011, 3'b001, 1'b0);
    run_txn("wr_ei",  2'b01, 3'b100, 3'b001, 3'b000, 0, 2, 3'b011, 3'b001, 1'b0);
    run_txn("wr_im",  2'b01, 3'b001, 3'b011, 3'b010, 1, 5, 3'b011, 3'b001, 1'b0);
    run_txn("rd_is",  2'b00, 3'b001, 3'b010, 3'b001, 0, 4, 3'b010, 3'b010, 1'b0);
    run_txn("rd_mi",  2'b00, 3'b011, 3'b001, 3'b000, 0, 2, 3'b011, 3'b001, 1'b0);
    run_txn("wr_mi",  2'b01, 3'b011, 3'b001, 3'b000, 0, 2, 3'b011, 3'b001, 1'b0);
    run_txn("ill_wr", 2'b10, 3'b010, 3'b100, 3'b000, 0, 2, 3'b010, 3'b100, 1'b1);

    // Results and Error hold while idle.
    repeat (3) @(negedge Clock);
    check("hold:err", Error, 1);
    check("hold:ns1", NewState1, 3'b010);
    check("hold:ns2", NewState2, 3'b100);

    run_txn("ill_s1", 2'b00, 3'b000, 3'b001, 3'b000, 0, 2, 3'b000, 3'b001, 1'b1);
    run_txn("ill_s2", 2'b01, 3'b001, 3'b111, 3'b000, 0, 2, 3'b001, 3'b111, 1'b1);
    run_txn("clr_err",2'b00, 3'b001, 3'b001, 3'b001, 0, 4, 3'b100, 3'b001, 1'b0);

    // Reset during BUS discards the transaction.
    Valid = 1'b1; WriteRead = 2'b00; state1 = 3'b001; state2 = 3'b001;
    @(posedge Clock); #1;
    Valid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("mid:bus_before", Bus, 3'b001);
    #2 Reset_n = 1'b0;
    #1 check_reset_vals("mid");
    @(negedge Clock);
    Reset_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    check("mid:no_done", dones, 0);
    check("mid:cnt", TxnCount, 0);
    check("mid:ready", Ready, 1);

    // 256 back-to-back read hits with Valid held high.
    Valid = 1'b1; WriteRead = 2'b00; state1 = 3'b010; state2 = 3'b010;
    dones = 0; cyc = 0; last = -1; gap_bad = 0; cnt_bad = 0;
    while (dones < 256 && cyc < 2000) begin
      if (Ready) begin
        if (last >= 0 && cyc - last != 3) gap_bad++;
        last = cyc;
      end
      if (Done) begin
        dones++;
        if (TxnCount != 8'(dones)) cnt_bad++;
        if (dones == 256) Valid = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    check("b2b:dones", dones, 256);
    check("b2b:gap_bad", gap_bad, 0);
    check("b2b:cnt_bad", cnt_bad, 0);
    check("b2b:wrap", TxnCount, 0);
    check("b2b:ready", Ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
